wm8731_i2c_responder: RTL and testbench



---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_line_sync.sv | 37 +++
 rtl/wm8731_i2c_responder.sv | 182 ++++++++++++++++++
 tb/tb_wm8731_i2c_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731 control-port responder.
package i2c_pkg;

    localparam int unsigned REG_ADDR_W = 7;
    localparam int unsigned REG_DATA_W = 9;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned COUNT_W    = 8;

    localparam logic [6:0] WM8731_ADDR    = 7'h1A;
    localparam logic [7:0] WM8731_WR_BYTE = 8'h34;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        EXTRA,
        WAIT_STOP
    } i2c_rsp_state_t;

    // One decoded register write as seen by the codec.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wm_reg_wr_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one asynchronous bus line, plus registered rise/fall pulses.
module i2c_line_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;
    logic              rise_q;
    logic              fall_q;

    // Idle bus is high, so the chain presets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            last_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            last_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~last_q;
            fall_q <= ~sync_q[STAGES-1] & last_q;
        end
    end

    assign level_o = last_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port I2C target: ACKs 3-byte write frames and strobes out
// each decoded register write. SDA is open-drain (pull-low enable only).
module wm8731_i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = WM8731_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    output logic [REG_ADDR_W-1:0] o_reg_addr,
    output logic [REG_DATA_W-1:0] o_reg_data,
    output logic                  o_reg_valid,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [COUNT_W-1:0]    o_write_count
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .line_i  (i_scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .line_i  (i_sda),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_rsp_state_t        state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [REG_ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic                  data8_q, data8_d;
    wm_reg_wr_t            commit_q, commit_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  reg_valid_q, reg_valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    logic              scl_edge, start_det, stop_det, byte_done;
    logic [BYTE_W-1:0] rx_byte;

    // An SCL edge in the same cycle masks START/STOP decoding.
    assign scl_edge  = scl_rise | scl_fall;
    assign start_det = sda_fall & scl_lvl & ~scl_edge;
    assign stop_det  = sda_rise & scl_lvl & ~scl_edge;
    assign rx_byte   = {shift_q[BYTE_W-2:0], sda_lvl};
    assign byte_done = scl_rise && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pend_addr_q <= '0;
            data8_q     <= 1'b0;
            commit_q    <= '0;
            sda_oe_q    <= 1'b0;
            reg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_addr_q <= pend_addr_d;
            data8_q     <= data8_d;
            commit_q    <= commit_d;
            sda_oe_q    <= sda_oe_d;
            reg_valid_q <= reg_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pend_addr_d = pend_addr_q;
        data8_d     = data8_q;
        commit_d    = commit_q;
        sda_oe_d    = sda_oe_q;
        reg_valid_d = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        count_d     = count_q;

        if (start_det || stop_det) begin
            // Frame cut short after the address ACK but before the commit.
            if (state_q inside {REG, REG_ACK, DATA}) begin
                err_d = 1'b1;
            end
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            busy_d    = start_det;
            state_d   = start_det ? ADDR : IDLE;
        end else begin
            if (scl_rise && (state_q inside {ADDR, REG, DATA, EXTRA})) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end

            case (state_q)
                ADDR: begin
                    if (byte_done) begin
                        if (rx_byte == {DEV_ADDR, 1'b0}) begin
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                            err_d   = (rx_byte[BYTE_W-1:1] == DEV_ADDR);
                        end
                    end
                end
                REG: begin
                    if (byte_done) begin
                        pend_addr_d = rx_byte[BYTE_W-1:1];
                        data8_d     = rx_byte[0];
                        state_d     = REG_ACK;
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        commit_d.addr = pend_addr_q;
                        commit_d.data = {data8_q, rx_byte};
                        reg_valid_d   = 1'b1;
                        count_d       = count_q + COUNT_W'(1);
                        state_d       = DATA_ACK;
                    end
                end
                EXTRA: begin
                    if (byte_done) begin
                        err_d   = 1'b1;
                        state_d = WAIT_STOP;
                    end
                end
                // First SCL fall drives the ACK, the second releases it.
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            case (state_q)
                                ADDR_ACK: state_d = REG;
                                REG_ACK:  state_d = DATA;
                                default:  state_d = EXTRA;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_oe      = sda_oe_q;
    assign o_reg_addr    = commit_q.addr;
    assign o_reg_data    = commit_q.data;
    assign o_reg_valid   = reg_valid_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;
    assign o_write_count = count_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for wm8731_i2c_responder: bit-banged I2C master, table vectors,
// random frames against a frame-level model, and the initializer sequence.
module tb_wm8731_i2c_responder;
    import i2c_pkg::*;

    localparam logic [6:0] DEV = WM8731_ADDR;

    typedef logic [4:0][7:0] frame_t;
    typedef struct {
        int         q;
        int         n;
        frame_t     b;
        logic [4:0] ack;
        bit         commit;
        logic [6:0] addr;
        logic [8:0] data;
        int         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m, sda_bus;
    logic       o_sda_oe, o_reg_valid, o_busy, o_err;
    logic [6:0] o_reg_addr;
    logic [8:0] o_reg_data;
    logic [7:0] o_write_count;

    int n_pass = 0;
    int n_total = 0;
    int q_len = 8;
    int exp_count = 0;
    logic [6:0] exp_addr = '0;
    logic [8:0] exp_data = '0;

    int mon_valid = 0, mon_err = 0, mon_long = 0, mon_oe = 0;
    bit prev_v = 1'b0, prev_e = 1'b0;

    assign sda_bus = sda_m & ~o_sda_oe;

    always #5 clk = ~clk;

    wm8731_i2c_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scl         (scl_m),
        .i_sda         (sda_bus),
        .o_sda_oe      (o_sda_oe),
        .o_reg_addr    (o_reg_addr),
        .o_reg_data    (o_reg_data),
        .o_reg_valid   (o_reg_valid),
        .o_busy        (o_busy),
        .o_err         (o_err),
        .o_write_count (o_write_count)
    );

    // Strobe and SDA-pull activity monitor.
    always @(negedge clk) begin
        if (o_reg_valid) begin
            mon_valid++;
            if (prev_v) mon_long++;
        end
        if (o_err) begin
            mon_err++;
            if (prev_e) mon_long++;
        end
        if (o_sda_oe) mon_oe++;
        prev_v = o_reg_valid;
        prev_e = o_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(q_len);
        scl_m = 1'b1; tick(q_len);
        sda_m = 1'b0; tick(q_len);
        scl_m = 1'b0; tick(q_len);
    endtask

    task automatic bus_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            sda_m = b[7-i]; tick(q_len);
            scl_m = 1'b1;   tick(2 * q_len);
            scl_m = 1'b0;   tick(q_len);
        end
    endtask

    task automatic bus_ack(output logic acked);
        sda_m = 1'b1; tick(q_len);
        scl_m = 1'b1; tick(q_len);
        acked = ~sda_bus;
        tick(q_len);
        scl_m = 1'b0; tick(q_len);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(q_len);
        scl_m = 1'b1; tick(q_len);
        sda_m = 1'b1; tick(2 * q_len);
    endtask

    // Frame-level reference: outcome of a write frame of n bytes closed by STOP.
    function automatic void model(input frame_t b, input int n, output logic [4:0] ack,
                                  output bit commit, output logic [6:0] a,
                                  output logic [8:0] d, output int err);
        ack = '0; commit = 1'b0; a = '0; d = '0; err = 0;
        if (b[0] != {DEV, 1'b0}) begin
            err = (b[0][7:1] == DEV) ? 1 : 0;
        end else begin
            for (int i = 0; i < n && i < 3; i++) ack[i] = 1'b1;
            if (n >= 3) begin
                commit = 1'b1;
                a = b[1][7:1];
                d = {b[1][0], b[2]};
            end
            if (n != 3) err = 1;
        end
    endfunction

    task automatic run_and_check(input string name, input frame_t b, input int n,
                                 input logic [4:0] e_ack, input bit e_commit,
                                 input logic [6:0] e_addr, input logic [8:0] e_data,
                                 input int e_err);
        int v0, e0, o0;
        logic a;
        logic [4:0] got_ack;
        logic busy_mid;
        v0 = mon_valid; e0 = mon_err; o0 = mon_oe;
        got_ack = '0;
        bus_start();
        busy_mid = o_busy;
        for (int i = 0; i < n; i++) begin
            bus_bits(b[i], 8);
            bus_ack(a);
            got_ack[i] = a;
        end
        bus_stop();
        if (e_commit) begin
            exp_count++;
            exp_addr = e_addr;
            exp_data = e_data;
        end
        check({name, " ack"}, 32'(got_ack), 32'(e_ack));
        check({name, " valid pulses"}, 32'(mon_valid - v0), e_commit ? 32'd1 : 32'd0);
        check({name, " err pulses"}, 32'(mon_err - e0), 32'(e_err));
        check({name, " reg_addr"}, 32'(o_reg_addr), 32'(exp_addr));
        check({name, " reg_data"}, 32'(o_reg_data), 32'(exp_data));
        check({name, " write_count"}, 32'(o_write_count), 32'(8'(exp_count)));
        check({name, " busy mid"}, 32'(busy_mid), 32'd1);
        check({name, " busy after stop"}, 32'(o_busy), 32'd0);
        check({name, " sda pulled"}, 32'((mon_oe - o0) != 0), 32'(|e_ack));
    endtask

    function automatic vec_t mk(input int q, input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [4:0] ack,
                                input bit c, input logic [6:0] a, input logic [8:0] d, input int e);
        vec_t v;
        v.q = q; v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = 8'h00;
        v.ack = ack; v.commit = c; v.addr = a; v.data = d; v.err = e;
        return v;
    endfunction

    vec_t       vecs [8];
    logic [15:0] init_cmd [11];

    initial begin
        frame_t     fb;
        logic [4:0] m_ack;
        bit         m_c;
        logic [6:0] m_a;
        logic [8:0] m_d;
        int         m_e, rn, r;
        logic       a;

        vecs[0] = mk(30, 3, WM8731_WR_BYTE, 8'h08, 8'h15, 8'h00, 5'b00111, 1'b1, 7'h04, 9'h015, 0);
        vecs[1] = mk(8, 3, 8'h34, 8'h1F, 8'hFF, 8'h00, 5'b00111, 1'b1, 7'h0F, 9'h1FF, 0);
        vecs[2] = mk(8, 3, 8'h36, 8'h08, 8'h15, 8'h00, 5'b00000, 1'b0, 7'h00, 9'h000, 0);
        vecs[3] = mk(8, 2, 8'h34, 8'h0C, 8'h00, 8'h00, 5'b00011, 1'b0, 7'h00, 9'h000, 1);
        vecs[4] = mk(8, 3, 8'h34, 8'h0C, 8'h00, 8'h00, 5'b00111, 1'b1, 7'h06, 9'h000, 0);
        vecs[5] = mk(8, 4, 8'h34, 8'h08, 8'h15, 8'h22, 5'b00111, 1'b1, 7'h04, 9'h015, 1);
        vecs[6] = mk(8, 2, 8'h35, 8'h08, 8'h00, 8'h00, 5'b00000, 1'b0, 7'h00, 9'h000, 1);
        vecs[7] = mk(8, 1, 8'h34, 8'h00, 8'h00, 8'h00, 5'b00001, 1'b0, 7'h00, 9'h000, 1);

        init_cmd[0]  = {7'h0F, 9'h000};
        init_cmd[1]  = {7'h06, 9'h010};
        init_cmd[2]  = {7'h00, 9'h017};
        init_cmd[3]  = {7'h01, 9'h017};
        init_cmd[4]  = {7'h02, 9'h079};
        init_cmd[5]  = {7'h03, 9'h079};
        init_cmd[6]  = {7'h04, 9'h012};
        init_cmd[7]  = {7'h05, 9'h000};
        init_cmd[8]  = {7'h07, 9'h00A};
        init_cmd[9]  = {7'h08, 9'h000};
        init_cmd[10] = {7'h09, 9'h001};

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        tick(4);
        check("reset sda_oe", 32'(o_sda_oe), 32'd0);
        check("reset reg_addr", 32'(o_reg_addr), 32'd0);
        check("reset reg_data", 32'(o_reg_data), 32'd0);
        check("reset reg_valid", 32'(o_reg_valid), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset err", 32'(o_err), 32'd0);
        check("reset write_count", 32'(o_write_count), 32'd0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 8; i++) begin
            q_len = vecs[i].q;
            run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].n, vecs[i].ack,
                          vecs[i].commit, vecs[i].addr, vecs[i].data, vecs[i].err);
        end
        q_len = 8;

        // Repeated START three bits into the register byte, then a clean frame.
        begin
            int v0, e0;
            v0 = mon_valid; e0 = mon_err;
            bus_start();
            bus_bits(8'h34, 8); bus_ack(a);
            check("rstart addr ack", 32'(a), 32'd1);
            bus_bits(8'h08, 3);
            bus_start();
            bus_bits(8'h34, 8); bus_ack(a);
            bus_bits(8'h02, 8); bus_ack(a);
            bus_bits(8'h55, 8); bus_ack(a);
            check("rstart data ack", 32'(a), 32'd1);
            bus_stop();
            exp_count++; exp_addr = 7'h01; exp_data = 9'h055;
            check("rstart err pulses", 32'(mon_err - e0), 32'd1);
            check("rstart valid pulses", 32'(mon_valid - v0), 32'd1);
            check("rstart reg_addr", 32'(o_reg_addr), 32'h01);
            check("rstart reg_data", 32'(o_reg_data), 32'h055);
        end

        for (int k = 0; k < 15; k++) begin
            rn = int'($urandom_range(1, 5));
            r  = int'($urandom_range(0, 9));
            fb = '0;
            fb[0] = (r < 6) ? 8'h34 : (r < 8) ? 8'h35 : 8'($urandom);
            for (int i = 1; i < 5; i++) fb[i] = 8'($urandom);
            model(fb, rn, m_ack, m_c, m_a, m_d, m_e);
            run_and_check($sformatf("rand%0d", k), fb, rn, m_ack, m_c, m_a, m_d, m_e);
        end

        // Reset while the responder is pulling SDA for the address ACK.
        bus_start();
        bus_bits(8'h34, 8);
        sda_m = 1'b1; tick(q_len);
        check("oe before reset", 32'(o_sda_oe), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("reset mid sda_oe", 32'(o_sda_oe), 32'd0);
        check("reset mid state", 32'(dut.state_q), 32'(IDLE));
        check("reset mid busy", 32'(o_busy), 32'd0);
        check("reset mid write_count", 32'(o_write_count), 32'd0);
        check("reset mid reg_data", 32'(o_reg_data), 32'd0);
        rst_n = 1'b1;
        exp_count = 0; exp_addr = '0; exp_data = '0;
        tick(4);
        bus_stop();

        for (int i = 0; i < 11; i++) begin
            fb = '0;
            fb[0] = WM8731_WR_BYTE;
            fb[1] = init_cmd[i][15:8];
            fb[2] = init_cmd[i][7:0];
            model(fb, 3, m_ack, m_c, m_a, m_d, m_e);
            run_and_check($sformatf("init%0d", i), fb, 3, m_ack, m_c, m_a, m_d, m_e);
        end
        check("init write_count", 32'(o_write_count), 32'd11);
        check("init last addr", 32'(o_reg_addr), 32'h09);
        check("init last data", 32'(o_reg_data), 32'h001);

        check("strobe width", 32'(mon_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
